uart_echo_buffer: RTL and testbench

- Parametrised store-and-forward buffer between the uart_rx byte strobe and the uart_tx load strobe, both in the osc_clk domain.
- Replaces the fixed single-delay echo path with configurable data width, buffer depth and release mode.
- Mode 0 forwards bytes as soon as the transmitter is free.
- Mode 1 holds bytes until the receive line has been idle for DELAY_CYCLES, then bursts out the whole buffer.

---
 rtl/uart_echo_buffer_pkg.sv | 20 ++
 rtl/echo_fifo.sv | 70 +++++++
 rtl/uart_echo_buffer.sv | 122 ++++++++++++
 tb/tb_uart_echo_buffer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_echo_buffer_pkg.sv
// rtl/uart_echo_buffer_pkg.sv - shared types, mode constants and width helper for the echo buffer.
package uart_echo_buffer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      LOAD,
      SEND,
      WAIT_DONE
   } state_e;

   localparam logic MODE_IMMEDIATE  = 1'b0;
   localparam logic MODE_IDLE_BURST = 1'b1;

   // Bits needed to index 'value' items; never less than one bit.
   function automatic int clog2w(input int value);
      return (value <= 2) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/echo_fifo.sv
// rtl/echo_fifo.sv - synchronous FIFO with registered read data and wrap-bit pointers.
module echo_fifo
   import uart_echo_buffer_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [WIDTH-1:0]          wr_data,
   input  logic                      rd_en,
   output logic [WIDTH-1:0]          rd_data,
   output logic                      full,
   output logic                      empty,
   output logic [clog2w(DEPTH):0]    count
);

   localparam int AW = clog2w(DEPTH);

   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0]  rd_data_q, rd_data_d;
   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [WIDTH-1:0]  mem_d [DEPTH];
   logic              wr_ok;
   logic              rd_ok;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count   = wr_ptr_q - rd_ptr_q;
   assign rd_data = rd_data_q;

   // A full FIFO drops the write even when a pop happens in the same cycle.
   assign wr_ok = wr_en && !full;
   assign rd_ok = rd_en && !empty;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      rd_data_d = rd_data_q;
      mem_d     = mem_q;
      if (wr_ok) begin
         mem_d[wr_ptr_q[AW-1:0]] = wr_data;
         wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
      end
      if (rd_ok) begin
         rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
         rd_ptr_d  = rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         rd_data_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         rd_data_q <= rd_data_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/uart_echo_buffer.sv
// rtl/uart_echo_buffer.sv - store-and-forward buffer from uart_rx strobes to uart_tx loads,
// releasing immediately or in a burst after the receive line goes idle.
module uart_echo_buffer
   import uart_echo_buffer_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int DEPTH        = 16,
   parameter int DELAY_CYCLES = 266000000
) (
   input  logic                      osc_clk,
   input  logic                      Reset,
   input  logic                      i_Rx_DV,
   input  logic [WIDTH-1:0]          i_Rx_Byte,
   input  logic                      i_Mode,
   input  logic                      i_Tx_Active,
   input  logic                      i_Tx_Done,
   output logic                      o_Tx_DV,
   output logic [WIDTH-1:0]          o_Tx_Byte,
   output logic [clog2w(DEPTH):0]    o_Count,
   output logic                      o_Overflow,
   output logic                      o_Draining
);

   localparam int              TW         = clog2w(DELAY_CYCLES + 1);
   localparam logic [TW-1:0]   TIMER_LAST = TW'(DELAY_CYCLES - 1);

   state_e         state_q, state_d;
   logic           mode_q, mode_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic           overflow_q, overflow_d;
   logic           rx_dv_q, rx_dv_d;
   logic           fifo_full;
   logic           fifo_empty;
   logic           fifo_rd;

   echo_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (osc_clk),
      .rst     (Reset),
      .wr_en   (i_Rx_DV),
      .wr_data (i_Rx_Byte),
      .rd_en   (fifo_rd),
      .rd_data (o_Tx_Byte),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (o_Count)
   );

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      timer_d    = timer_q;
      overflow_d = overflow_q | (i_Rx_DV & fifo_full);
      rx_dv_d    = i_Rx_DV;
      fifo_rd    = 1'b0;
      unique case (state_q)
         IDLE: begin
            mode_d = i_Mode;
            if (!fifo_empty) begin
               if (mode_q == MODE_IDLE_BURST) begin
                  state_d = WAIT;
                  timer_d = '0;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         WAIT: begin
            // Restart from the cycle a word lands in the buffer, so idle time is
            // measured the same way whether the word arrived in IDLE or in WAIT.
            if (rx_dv_q) begin
               timer_d = '0;
            end else if (timer_q != TIMER_LAST) begin
               timer_d = timer_q + TW'(1);
            end
            if (!i_Rx_DV && !rx_dv_q && timer_q == TIMER_LAST) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (!i_Tx_Active) begin
               fifo_rd = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (i_Tx_Done) begin
               state_d = fifo_empty ? IDLE : LOAD;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge osc_clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= IDLE;
         mode_q     <= MODE_IMMEDIATE;
         timer_q    <= '0;
         overflow_q <= 1'b0;
         rx_dv_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         timer_q    <= timer_d;
         overflow_q <= overflow_d;
         rx_dv_q    <= rx_dv_d;
      end
   end

   assign o_Tx_DV    = (state_q == SEND);
   assign o_Overflow = overflow_q;
   assign o_Draining = (state_q != IDLE) && (state_q != WAIT);

endmodule

// File: tb/tb_uart_echo_buffer.sv
// tb/tb_uart_echo_buffer.sv - self-checking bench for uart_echo_buffer.
module tb_uart_echo_buffer;

   localparam int DLY = 20;

   logic       osc_clk     = 1'b0;
   logic       Reset       = 1'b1;
   logic       i_Rx_DV     = 1'b0;
   logic [7:0] i_Rx_Byte   = 8'h00;
   logic       i_Mode      = 1'b0;
   logic       i_Tx_Active = 1'b0;
   logic       i_Tx_Done   = 1'b0;
   logic       o_Tx_DV;
   logic [7:0] o_Tx_Byte;
   logic [2:0] o_Count;
   logic       o_Overflow;
   logic       o_Draining;

   int         cyc = 0;
   int         n_checks = 0;
   int         n_errors = 0;
   int         ev_cyc[$];
   logic [7:0] ev_byte[$];
   int         max_count = 0;
   bit         tx_busy = 1'b0;
   int         tx_start = 0;

   uart_echo_buffer #(.WIDTH(8), .DEPTH(4), .DELAY_CYCLES(DLY)) dut (
      .osc_clk     (osc_clk),
      .Reset       (Reset),
      .i_Rx_DV     (i_Rx_DV),
      .i_Rx_Byte   (i_Rx_Byte),
      .i_Mode      (i_Mode),
      .i_Tx_Active (i_Tx_Active),
      .i_Tx_Done   (i_Tx_Done),
      .o_Tx_DV     (o_Tx_DV),
      .o_Tx_Byte   (o_Tx_Byte),
      .o_Count     (o_Count),
      .o_Overflow  (o_Overflow),
      .o_Draining  (o_Draining)
   );

   always #5 osc_clk = ~osc_clk;
   always @(posedge osc_clk) cyc <= cyc + 1;

   // Strobe log plus a uart_tx model: Active for 10 cycles after DV, then one Done pulse.
   always @(negedge osc_clk) begin
      if (Reset) begin
         tx_busy     = 1'b0;
         i_Tx_Active = 1'b0;
         i_Tx_Done   = 1'b0;
      end else begin
         if (o_Tx_DV === 1'b1) begin
            ev_cyc.push_back(cyc);
            ev_byte.push_back(o_Tx_Byte);
            tx_busy  = 1'b1;
            tx_start = cyc;
         end
         if (int'(o_Count) > max_count) max_count = int'(o_Count);
         i_Tx_Active = tx_busy && (cyc >= tx_start + 1) && (cyc <= tx_start + 10);
         i_Tx_Done   = tx_busy && (cyc == tx_start + 11);
         if (tx_busy && cyc >= tx_start + 11) tx_busy = 1'b0;
      end
   end

   task automatic apply_reset();
      @(negedge osc_clk);
      Reset   = 1'b1;
      i_Rx_DV = 1'b0;
      repeat (3) @(negedge osc_clk);
      Reset = 1'b0;
   endtask

   task automatic clear_log();
      ev_cyc.delete();
      ev_byte.delete();
      max_count = 0;
   endtask

   task automatic send_at(input int t, input logic [7:0] b);
      while (cyc < t) @(negedge osc_clk);
      i_Rx_Byte = b;
      i_Rx_DV   = 1'b1;
      @(negedge osc_clk);
      i_Rx_DV   = 1'b0;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge osc_clk);
   endtask

   task automatic test_reset();
      @(negedge osc_clk);
      Reset = 1'b1;
      @(negedge osc_clk);
      n_checks += 5;
      if (o_Tx_DV !== 1'b0) begin n_errors++; $display("FAIL reset_tx_dv: got %b expected 0", o_Tx_DV); end
      if (o_Tx_Byte !== 8'h00) begin n_errors++; $display("FAIL reset_tx_byte: got %h expected 00", o_Tx_Byte); end
      if (o_Count !== 3'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", o_Count); end
      if (o_Overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow: got %b expected 0", o_Overflow); end
      if (o_Draining !== 1'b0) begin n_errors++; $display("FAIL reset_draining: got %b expected 0", o_Draining); end
      Reset = 1'b0;
   endtask

   task automatic test_mode0_single();
      int t0;
      i_Mode = 1'b0;
      apply_reset();
      clear_log();
      t0 = cyc;
      send_at(t0 + 10, 8'hA5);
      wait_until(t0 + 40);
      n_checks++;
      if (ev_cyc.size() !== 1) begin n_errors++; $display("FAIL single_count: got %0d strobes expected 1", ev_cyc.size()); end
      if (ev_cyc.size() >= 1) begin
         n_checks += 2;
         if (ev_cyc[0] - t0 !== 13) begin n_errors++; $display("FAIL single_latency: got cycle %0d expected 13", ev_cyc[0] - t0); end
         if (ev_byte[0] !== 8'hA5) begin n_errors++; $display("FAIL single_byte: got %h expected a5", ev_byte[0]); end
      end
      n_checks += 2;
      if (o_Count !== 3'd0) begin n_errors++; $display("FAIL single_drained: got %0d expected 0", o_Count); end
      if (o_Tx_Byte !== 8'hA5) begin n_errors++; $display("FAIL single_hold: got %h expected a5", o_Tx_Byte); end
   endtask

   task automatic test_mode1_burst();
      int t0;
      int exp_c;
      i_Mode = 1'b1;
      apply_reset();
      repeat (2) @(negedge osc_clk);
      clear_log();
      t0 = cyc;
      send_at(t0 + 20, 8'h01);
      send_at(t0 + 25, 8'h02);
      send_at(t0 + 30, 8'h03);
      wait_until(t0 + 110);
      n_checks++;
      if (ev_cyc.size() !== 3) begin n_errors++; $display("FAIL burst_count: got %0d expected 3", ev_cyc.size()); end
      exp_c = 30 + DLY + 3;
      for (int i = 0; i < ev_cyc.size() && i < 3; i++) begin
         n_checks += 2;
         if (ev_cyc[i] - t0 !== exp_c) begin n_errors++; $display("FAIL burst_cycle%0d: got %0d expected %0d", i, ev_cyc[i] - t0, exp_c); end
         if (ev_byte[i] !== 8'(i + 1)) begin n_errors++; $display("FAIL burst_byte%0d: got %h expected %h", i, ev_byte[i], 8'(i + 1)); end
         exp_c = exp_c + 13;
      end
   endtask

   task automatic test_timer_restart();
      int t0;
      logic [7:0] b0, b1;
      i_Mode = 1'b1;
      apply_reset();
      repeat (2) @(negedge osc_clk);
      clear_log();
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      t0 = cyc;
      send_at(t0, b0);
      send_at(t0 + 15, b1);
      wait_until(t0 + 80);
      n_checks++;
      if (ev_cyc.size() !== 2) begin n_errors++; $display("FAIL restart_count: got %0d expected 2", ev_cyc.size()); end
      if (ev_cyc.size() == 2) begin
         n_checks += 4;
         if (ev_cyc[0] - t0 !== 38) begin n_errors++; $display("FAIL restart_first: got %0d expected 38", ev_cyc[0] - t0); end
         if (ev_cyc[1] - t0 !== 51) begin n_errors++; $display("FAIL restart_second: got %0d expected 51", ev_cyc[1] - t0); end
         if (ev_byte[0] !== b0) begin n_errors++; $display("FAIL restart_byte0: got %h expected %h", ev_byte[0], b0); end
         if (ev_byte[1] !== b1) begin n_errors++; $display("FAIL restart_byte1: got %h expected %h", ev_byte[1], b1); end
      end
   endtask

   task automatic test_overflow();
      int t0;
      i_Mode = 1'b1;
      apply_reset();
      repeat (2) @(negedge osc_clk);
      clear_log();
      t0 = cyc;
      for (int i = 0; i < 6; i++) send_at(t0 + i, 8'(8'h10 + i));
      wait_until(t0 + 7);
      n_checks += 2;
      if (o_Count !== 3'd4) begin n_errors++; $display("FAIL ovf_count: got %0d expected 4", o_Count); end
      if (o_Overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_flag: got %b expected 1", o_Overflow); end
      wait_until(t0 + 180);
      n_checks++;
      if (ev_cyc.size() !== 4) begin n_errors++; $display("FAIL ovf_emitted: got %0d expected 4", ev_cyc.size()); end
      for (int i = 0; i < ev_cyc.size() && i < 4; i++) begin
         n_checks += 2;
         if (ev_cyc[i] - t0 !== 5 + DLY + 3 + 13 * i) begin n_errors++; $display("FAIL ovf_cycle%0d: got %0d expected %0d", i, ev_cyc[i] - t0, 5 + DLY + 3 + 13 * i); end
         if (ev_byte[i] !== 8'(8'h10 + i)) begin n_errors++; $display("FAIL ovf_byte%0d: got %h expected %h", i, ev_byte[i], 8'(8'h10 + i)); end
      end
      n_checks++;
      if (o_Overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky: got %b expected 1", o_Overflow); end
      apply_reset();
      n_checks++;
      if (o_Overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_cleared: got %b expected 0", o_Overflow); end
   endtask

   task automatic test_wrap();
      int t0;
      int wt[10];
      logic [7:0] data[10];
      i_Mode = 1'b0;
      apply_reset();
      clear_log();
      t0 = cyc;
      // Three early words keep two queued; later writes land exactly on the LOAD pops.
      for (int i = 0; i < 10; i++) begin
         wt[i]   = (i < 3) ? i : 15 + 13 * (i - 3);
         data[i] = 8'($urandom);
      end
      for (int i = 0; i < 10; i++) send_at(t0 + wt[i], data[i]);
      wait_until(t0 + 3 + 13 * 9 + 20);
      n_checks++;
      if (ev_cyc.size() !== 10) begin n_errors++; $display("FAIL wrap_count: got %0d expected 10", ev_cyc.size()); end
      for (int i = 0; i < ev_cyc.size() && i < 10; i++) begin
         n_checks += 2;
         if (ev_cyc[i] - t0 !== 3 + 13 * i) begin n_errors++; $display("FAIL wrap_cycle%0d: got %0d expected %0d", i, ev_cyc[i] - t0, 3 + 13 * i); end
         if (ev_byte[i] !== data[i]) begin n_errors++; $display("FAIL wrap_byte%0d: got %h expected %h", i, ev_byte[i], data[i]); end
      end
      n_checks += 3;
      if (max_count > 4) begin n_errors++; $display("FAIL wrap_max_count: got %0d expected <=4", max_count); end
      if (o_Count !== 3'd0) begin n_errors++; $display("FAIL wrap_final_count: got %0d expected 0", o_Count); end
      if (o_Overflow !== 1'b0) begin n_errors++; $display("FAIL wrap_overflow: got %b expected 0", o_Overflow); end
   endtask

   task automatic test_reset_mid_burst();
      int t0;
      i_Mode = 1'b0;
      apply_reset();
      clear_log();
      t0 = cyc;
      for (int i = 0; i < 3; i++) send_at(t0 + i, 8'($urandom) | 8'h01);
      wait_until(t0 + 8);
      n_checks += 2;
      if (o_Count !== 3'd2) begin n_errors++; $display("FAIL mid_queued: got %0d expected 2", o_Count); end
      if (o_Draining !== 1'b1) begin n_errors++; $display("FAIL mid_draining: got %b expected 1", o_Draining); end
      Reset = 1'b1;
      #1;
      n_checks += 5;
      if (o_Tx_DV !== 1'b0) begin n_errors++; $display("FAIL mid_tx_dv: got %b expected 0", o_Tx_DV); end
      if (o_Tx_Byte !== 8'h00) begin n_errors++; $display("FAIL mid_tx_byte: got %h expected 00", o_Tx_Byte); end
      if (o_Count !== 3'd0) begin n_errors++; $display("FAIL mid_count: got %0d expected 0", o_Count); end
      if (o_Overflow !== 1'b0) begin n_errors++; $display("FAIL mid_overflow: got %b expected 0", o_Overflow); end
      if (o_Draining !== 1'b0) begin n_errors++; $display("FAIL mid_draining_rst: got %b expected 0", o_Draining); end
      repeat (2) @(negedge osc_clk);
      Reset = 1'b0;
      clear_log();
      repeat (100) @(negedge osc_clk);
      n_checks += 2;
      if (ev_cyc.size() !== 0) begin n_errors++; $display("FAIL mid_no_strobe: got %0d strobes expected 0", ev_cyc.size()); end
      if (o_Count !== 3'd0) begin n_errors++; $display("FAIL mid_still_empty: got %0d expected 0", o_Count); end
   endtask

   task automatic test_random_immediate();
      int t;
      int exp_c[$];
      logic [7:0] exp_b[$];
      logic [7:0] b;
      i_Mode = 1'b0;
      apply_reset();
      clear_log();
      t = cyc + 2;
      for (int i = 0; i < 8; i++) begin
         b = 8'($urandom);
         exp_c.push_back(t + 3);
         exp_b.push_back(b);
         send_at(t, b);
         t = t + int'($urandom_range(14, 25));
      end
      wait_until(t + 20);
      n_checks++;
      if (ev_cyc.size() !== exp_c.size()) begin n_errors++; $display("FAIL rimm_count: got %0d expected %0d", ev_cyc.size(), exp_c.size()); end
      for (int i = 0; i < ev_cyc.size() && i < exp_c.size(); i++) begin
         n_checks += 2;
         if (ev_cyc[i] !== exp_c[i]) begin n_errors++; $display("FAIL rimm_cycle%0d: got %0d expected %0d", i, ev_cyc[i], exp_c[i]); end
         if (ev_byte[i] !== exp_b[i]) begin n_errors++; $display("FAIL rimm_byte%0d: got %h expected %h", i, ev_byte[i], exp_b[i]); end
      end
   endtask

   task automatic test_random_burst();
      for (int r = 0; r < 3; r++) begin
         int t;
         int k;
         int last;
         logic [7:0] exp_b[$];
         logic [7:0] b;
         i_Mode = 1'b1;
         apply_reset();
         repeat (2) @(negedge osc_clk);
         clear_log();
         k = int'($urandom_range(1, 4));
         t = cyc + 1;
         last = t;
         for (int i = 0; i < k; i++) begin
            b = 8'($urandom);
            exp_b.push_back(b);
            send_at(t, b);
            last = t;
            t = t + int'($urandom_range(1, DLY - 1));
         end
         wait_until(last + DLY + 3 + 13 * k + 20);
         n_checks++;
         if (ev_cyc.size() !== k) begin n_errors++; $display("FAIL rburst%0d_count: got %0d expected %0d", r, ev_cyc.size(), k); end
         for (int i = 0; i < ev_cyc.size() && i < k; i++) begin
            n_checks += 2;
            if (ev_cyc[i] !== last + DLY + 3 + 13 * i) begin n_errors++; $display("FAIL rburst%0d_cycle%0d: got %0d expected %0d", r, i, ev_cyc[i], last + DLY + 3 + 13 * i); end
            if (ev_byte[i] !== exp_b[i]) begin n_errors++; $display("FAIL rburst%0d_byte%0d: got %h expected %h", r, i, ev_byte[i], exp_b[i]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_mode0_single();
      test_mode1_burst();
      test_timer_restart();
      test_overflow();
      test_wrap();
      test_reset_mid_burst();
      test_random_immediate();
      test_random_burst();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
